ex_issue_stage: RTL and testbench
=================================

Name: ex_issue_stage

Overview:
ID/EX pipeline register and ALU-control generator sitting directly upstream of the 16-bit ALU (chain of 1-bit slices).
- Latches decoded instruction fields.
- Derives per-slice ALU controls (op, binvert, bit-0 carry-in).
- Selects operand A/B with EX/MEM and MEM/WB forwarding.
- Detects load-use hazards and inserts bubbles.

Parameters:
WIDTH, 16, datapath width
REG_AW, 2, register address width (register 0 hardwired zero)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  global hold (memory wait); stage registers keep value
flush  input  1  branch taken; inject bubble
id_valid  input  1  ID stage holds valid instruction
id_opcode  input  4  instruction opcode
id_rs, id_rt, id_rd  input  REG_AW  register addresses
id_rs_data, id_rt_data  input  WIDTH  register-file read data
id_imm  input  WIDTH  sign-extended immediate
exm_wr_en  input  1  EX/MEM writes a register
exm_rd  input  REG_AW  EX/MEM destination
exm_result  input  WIDTH  EX/MEM ALU result
mwb_wr_en  input  1  MEM/WB writes a register
mwb_rd  input  REG_AW  MEM/WB destination
mwb_data  input  WIDTH  MEM/WB writeback data
hazard_stall  output  1  combinational load-use stall request to IF/ID
ex_valid  output  1  stage holds valid instruction
ex_a, ex_b  output  WIDTH  ALU operands (forwarded)
ex_store_data  output  WIDTH  forwarded rt for SW
ex_op  output  2  ALU op: 00 AND, 01 OR, 10 SUM, 11 LESS
ex_binvert  output  1  ALU b-invert
ex_carryin  output  1  carry-in to bit 0 (equals ex_binvert)
ex_rd  output  REG_AW  destination register
ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  output  1  control flags

Behaviour:
- Reset (rst_n low, asynchronous): all stage registers 0; outputs ex_valid=0, ex_op=00, ex_binvert=0, ex_carryin=0, ex_rd=0, all flags 0, ex_a=ex_b=ex_store_data=0, hazard_stall=0. Reset mid-stream discards the held instruction.
- Opcode decode, as (op, binvert, flags):
  - 0000 ADD: 10, 0, reg_write
  - 0001 SUB: 10, 1, reg_write
  - 0010 AND: 00, 0, reg_write
  - 0011 OR: 01, 0, reg_write
  - 0100 SLT: 11, 1, reg_write
  - 0101 ADDI: 10, 0, reg_write
  - 0110 LW: 10, 0, reg_write + mem_read
  - 0111 SW: 10, 0, mem_write
  - 1000 BEQ: 10, 1, branch
  - Other opcodes: NOP, all flags 0, op 00.
- Destination register:
  - ADDI and LW write rt; others write rd.
  - reg_write is forced 0 when the destination register is 0.
- Register update each rising edge, in priority order:
  1. flush: bubble (valid=0, all controls/flags 0, data 0).
  2. stall: hold all registers.
  3. hazard_stall: bubble.
  4. Otherwise: load ID fields, with valid=id_valid. If id_valid=0, load a bubble.
- hazard_stall = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & (ex_rd==id_rs | (ex_rd==id_rt & ID opcode reads rt)).
  - Opcodes that read rt: ADD, SUB, AND, OR, SLT, SW, BEQ.
  - hazard_stall is combinational and asserted regardless of stall or flush. Upstream uses it to hold IF/ID.
- Forwarding, combinational on registered rs/rt:
  - A source register of 0 always reads 0.
  - EX/MEM match (exm_wr_en, exm_rd==rs) wins over MEM/WB match. Otherwise use the latched register data.
- Operand selection:
  - ex_b = latched imm for ADDI/LW/SW; otherwise forwarded rt.
  - ex_store_data = forwarded rt.
- Latency: one cycle from ID capture to ex_* outputs; forwarding adds zero cycles.
- No combinational path from id_* to ex_* outputs. hazard_stall is the only combinational output from id_*.

Test Plan:
- Reset: rst_n=0 mid-cycle with a valid SUB loaded → ex_valid=0, ex_op=00, ex_binvert=0 immediately, without a clock edge.
- Decode: ADD r1,r2,r3 with rs_data=5, rt_data=3 → next cycle ex_op=10, binvert=0, ex_a=5, ex_b=3. SLT → ex_op=11, binvert=1, carryin=1.
- Forwarding: rs=2 with exm_wr_en=1, exm_rd=2, exm_result=0x00AA, and mwb_rd=2, mwb_data=0x0055 → ex_a=0x00AA. Deassert exm_wr_en → ex_a=0x0055. rs=0 with both matching → ex_a=0.
- Load-use: LW r1 in EX, ID holds ADD using rs=1 → hazard_stall=1. Next edge EX holds a bubble (ex_valid=0). The ADD enters the following cycle with MEM/WB forwarding.
- Stall/flush priority: stall=1 and flush=1 together → bubble. stall=1 alone for 3 cycles → outputs unchanged, then advance on release.
- Immediate/zero destination: ADDI rt=0, imm=0xFFFF → ex_b=0xFFFF, ex_reg_write=0. SW → ex_b=imm, ex_store_data=forwarded rt, ex_mem_write=1.

Source files
------------

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register feeding a 16-bit ripple ALU: latches decoded fields,
// derives per-slice ALU controls, forwards operands and raises load-use stalls.
module ex_issue_stage #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [WIDTH-1:0]  id_rs_data,
  input  logic [WIDTH-1:0]  id_rt_data,
  input  logic [WIDTH-1:0]  id_imm,
  input  logic              exm_wr_en,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [WIDTH-1:0]  exm_result,
  input  logic              mwb_wr_en,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [WIDTH-1:0]  mwb_data,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [WIDTH-1:0]  ex_a,
  output logic [WIDTH-1:0]  ex_b,
  output logic [WIDTH-1:0]  ex_store_data,
  output logic [1:0]        ex_op,
  output logic              ex_binvert,
  output logic              ex_carryin,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_SLT = 4'd4, OP_ADDI = 4'd5, OP_LW = 4'd6, OP_SW = 4'd7,
                         OP_BEQ = 4'd8;

  typedef struct packed {
    logic              valid;
    logic [1:0]        op;
    logic              binv;
    logic [REG_AW-1:0] rd;
    logic              regw;
    logic              memr;
    logic              memw;
    logic              br;
    logic              use_imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [WIDTH-1:0]  rs_data;
    logic [WIDTH-1:0]  rt_data;
    logic [WIDTH-1:0]  imm;
  } ex_reg_t;

  ex_reg_t dec, ex_d, ex_q;
  logic    regw_raw, reads_rt;

  always_comb begin
    dec      = '0;
    regw_raw = 1'b0;
    reads_rt = 1'b0;
    dec.valid   = 1'b1;
    dec.rs      = id_rs;
    dec.rt      = id_rt;
    dec.rs_data = id_rs_data;
    dec.rt_data = id_rt_data;
    dec.imm     = id_imm;
    dec.rd      = (id_opcode == OP_ADDI || id_opcode == OP_LW) ? id_rt : id_rd;
    case (id_opcode)
      OP_ADD:  begin dec.op = 2'b10;                   regw_raw = 1'b1; reads_rt = 1'b1; end
      OP_SUB:  begin dec.op = 2'b10; dec.binv = 1'b1;  regw_raw = 1'b1; reads_rt = 1'b1; end
      OP_AND:  begin dec.op = 2'b00;                   regw_raw = 1'b1; reads_rt = 1'b1; end
      OP_OR:   begin dec.op = 2'b01;                   regw_raw = 1'b1; reads_rt = 1'b1; end
      OP_SLT:  begin dec.op = 2'b11; dec.binv = 1'b1;  regw_raw = 1'b1; reads_rt = 1'b1; end
      OP_ADDI: begin dec.op = 2'b10; dec.use_imm = 1'b1; regw_raw = 1'b1; end
      OP_LW:   begin dec.op = 2'b10; dec.use_imm = 1'b1; regw_raw = 1'b1; dec.memr = 1'b1; end
      OP_SW:   begin dec.op = 2'b10; dec.use_imm = 1'b1; dec.memw = 1'b1; reads_rt = 1'b1; end
      OP_BEQ:  begin dec.op = 2'b10; dec.binv = 1'b1;  dec.br = 1'b1;   reads_rt = 1'b1; end
      default: ;
    endcase
    // Writes to register 0 are architecturally dropped.
    dec.regw = regw_raw & (dec.rd != '0);
  end

  assign hazard_stall = id_valid & ex_q.valid & ex_q.memr & (ex_q.rd != '0) &
                        ((ex_q.rd == id_rs) | ((ex_q.rd == id_rt) & reads_rt));

  always_comb begin
    ex_d = ex_q;
    if (flush)                           ex_d = '0;
    else if (stall)                      ex_d = ex_q;
    else if (hazard_stall || !id_valid)  ex_d = '0;
    else                                 ex_d = dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  logic [WIDTH-1:0] fwd_a, fwd_b;

  // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
  always_comb begin
    fwd_a = ex_q.rs_data;
    if (ex_q.rs == '0)                         fwd_a = '0;
    else if (exm_wr_en && exm_rd == ex_q.rs)   fwd_a = exm_result;
    else if (mwb_wr_en && mwb_rd == ex_q.rs)   fwd_a = mwb_data;
  end

  always_comb begin
    fwd_b = ex_q.rt_data;
    if (ex_q.rt == '0)                         fwd_b = '0;
    else if (exm_wr_en && exm_rd == ex_q.rt)   fwd_b = exm_result;
    else if (mwb_wr_en && mwb_rd == ex_q.rt)   fwd_b = mwb_data;
  end

  assign ex_valid      = ex_q.valid;
  assign ex_a          = fwd_a;
  assign ex_b          = ex_q.use_imm ? ex_q.imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign ex_op         = ex_q.op;
  assign ex_binvert    = ex_q.binv;
  assign ex_carryin    = ex_q.binv;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.regw;
  assign ex_mem_read   = ex_q.memr;
  assign ex_mem_write  = ex_q.memw;
  assign ex_branch     = ex_q.br;
endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage: expected EX contents are queued when an
// instruction is driven and compared once the clock edge has captured it.
module tb_ex_issue_stage;
  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [3:0]  id_opcode = '0;
  logic [1:0]  id_rs = '0, id_rt = '0, id_rd = '0, exm_rd = '0, mwb_rd = '0;
  logic [15:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0, exm_result = '0, mwb_data = '0;
  logic        exm_wr_en = 1'b0, mwb_wr_en = 1'b0;
  logic        hazard_stall, ex_valid, ex_binvert, ex_carryin;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [15:0] ex_a, ex_b, ex_store_data;
  logic [1:0]  ex_op, ex_rd;

  ex_issue_stage #(.WIDTH(16), .REG_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .ex_op(ex_op), .ex_binvert(ex_binvert),
    .ex_carryin(ex_carryin), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [1:0] op; logic bi; logic [1:0] rd;
    logic rw, mr, mw, br; logic [15:0] a, b, sd;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic v, input logic [1:0] op, input logic bi,
                      input logic [1:0] rd, input logic rw, input logic mr, input logic mw,
                      input logic br, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] sd);
    exp_t e;
    e.v = v; e.op = op; e.bi = bi; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw; e.br = br;
    e.a = a; e.b = b; e.sd = sd;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic bubble(input string tag);
    push(tag, 0, 2'b00, 0, 2'd0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
  endtask

  // Advance one edge, then compare the oldest queued expectation.
  task automatic step();
    exp_t  e;
    string t;
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb_q.pop_front(); t = tag_q.pop_front();
    chk({t, ".valid"}, ex_valid, e.v);
    chk({t, ".op"}, ex_op, e.op);
    chk({t, ".binv"}, ex_binvert, e.bi);
    chk({t, ".cin"}, ex_carryin, e.bi);
    chk({t, ".rd"}, ex_rd, e.rd);
    chk({t, ".rw"}, ex_reg_write, e.rw);
    chk({t, ".mr"}, ex_mem_read, e.mr);
    chk({t, ".mw"}, ex_mem_write, e.mw);
    chk({t, ".br"}, ex_branch, e.br);
    chk({t, ".a"}, ex_a, e.a);
    chk({t, ".b"}, ex_b, e.b);
    chk({t, ".sd"}, ex_store_data, e.sd);
  endtask

  task automatic id(input logic v, input logic [3:0] opc, input logic [1:0] rs,
                    input logic [1:0] rt, input logic [1:0] rd, input logic [15:0] rsd,
                    input logic [15:0] rtd, input logic [15:0] imm);
    @(negedge clk);
    id_valid = v; id_opcode = opc; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    bubble("reset");
    sb_q.pop_front(); tag_q.pop_front();
    chk("reset.valid", ex_valid, 1'b0);
    chk("reset.op", ex_op, 2'b00);
    chk("reset.a", ex_a, 16'h0);
    chk("reset.hz", hazard_stall, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Decode: ADD r1,r2,r3 then SLT
    id(1, 4'd0, 2'd2, 2'd3, 2'd1, 16'd5, 16'd3, 16'h0);
    push("add", 1, 2'b10, 0, 2'd1, 1, 0, 0, 0, 16'd5, 16'd3, 16'd3); step();
    id(1, 4'd4, 2'd1, 2'd2, 2'd3, 16'd7, 16'd9, 16'h0);
    push("slt", 1, 2'b11, 1, 2'd3, 1, 0, 0, 0, 16'd7, 16'd9, 16'd9); step();

    // Forwarding priority
    id(1, 4'd0, 2'd2, 2'd3, 2'd1, 16'h1111, 16'h0022, 16'h0);
    exm_wr_en = 1; exm_rd = 2'd2; exm_result = 16'h00AA;
    mwb_wr_en = 1; mwb_rd = 2'd2; mwb_data = 16'h0055;
    push("fwd_exm", 1, 2'b10, 0, 2'd1, 1, 0, 0, 0, 16'h00AA, 16'h0022, 16'h0022); step();
    exm_wr_en = 0; #1;
    chk("fwd_mwb.a", ex_a, 16'h0055);
    id(1, 4'd0, 2'd0, 2'd0, 2'd1, 16'h1234, 16'h5678, 16'h0);
    exm_wr_en = 1; exm_rd = 2'd0; mwb_rd = 2'd0;
    push("fwd_r0", 1, 2'b10, 0, 2'd1, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0); step();
    exm_wr_en = 0; mwb_wr_en = 0;

    // Load-use hazard
    id(1, 4'd6, 2'd2, 2'd1, 2'd3, 16'h0100, 16'h0007, 16'h0010);
    push("lw", 1, 2'b10, 0, 2'd1, 1, 1, 0, 0, 16'h0100, 16'h0010, 16'h0007); step();
    id(1, 4'd0, 2'd1, 2'd2, 2'd3, 16'h0999, 16'h0004, 16'h0);
    #1 chk("hz.on", hazard_stall, 1'b1);
    bubble("hz_bubble"); step();
    chk("hz.off", hazard_stall, 1'b0);
    @(negedge clk); mwb_wr_en = 1; mwb_rd = 2'd1; mwb_data = 16'h0555;
    push("hz_add", 1, 2'b10, 0, 2'd3, 1, 0, 0, 0, 16'h0555, 16'h0004, 16'h0004); step();
    mwb_wr_en = 0;

    // LW r2 followed by ADDI with rt=2: ADDI does not read rt, so no stall
    id(1, 4'd6, 2'd0, 2'd2, 2'd0, 16'h0, 16'h0, 16'h0020);
    push("lw2", 1, 2'b10, 0, 2'd2, 1, 1, 0, 0, 16'h0, 16'h0020, 16'h0); step();
    id(1, 4'd5, 2'd3, 2'd2, 2'd0, 16'h0003, 16'h0, 16'h0001);
    #1 chk("hz.addi_rt", hazard_stall, 1'b0);

    // ADDI to r0 is dropped; imm sign-extended value passes to b
    id(1, 4'd5, 2'd1, 2'd0, 2'd2, 16'h0002, 16'h0, 16'hFFFF);
    push("addi_r0", 1, 2'b10, 0, 2'd0, 0, 0, 0, 0, 16'h0002, 16'hFFFF, 16'h0); step();

    // SW with forwarded store data
    id(1, 4'd7, 2'd1, 2'd2, 2'd3, 16'h0040, 16'h0033, 16'h0008);
    exm_wr_en = 1; exm_rd = 2'd2; exm_result = 16'hBEEF;
    push("sw", 1, 2'b10, 0, 2'd3, 0, 0, 1, 0, 16'h0040, 16'h0008, 16'hBEEF); step();

    // Stall holds for three edges, then AND advances
    id(1, 4'd2, 2'd3, 2'd1, 2'd2, 16'h0F0F, 16'h00FF, 16'h0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      push("stall_hold", 1, 2'b10, 0, 2'd3, 0, 0, 1, 0, 16'h0040, 16'h0008, 16'hBEEF); step();
    end
    @(negedge clk); stall = 0; exm_wr_en = 0;
    push("and", 1, 2'b00, 0, 2'd2, 1, 0, 0, 0, 16'h0F0F, 16'h00FF, 16'h00FF); step();

    // Flush beats stall
    id(1, 4'd3, 2'd1, 2'd2, 2'd3, 16'h1, 16'h2, 16'h0);
    stall = 1; flush = 1;
    bubble("stall_flush"); step();
    @(negedge clk); stall = 0; flush = 0;
    push("or", 1, 2'b01, 0, 2'd3, 1, 0, 0, 0, 16'h1, 16'h2, 16'h2); step();
    id(1, 4'd8, 2'd1, 2'd2, 2'd1, 16'h0009, 16'h0009, 16'h0);
    flush = 1;
    bubble("flush"); step();
    @(negedge clk); flush = 0;
    push("beq", 1, 2'b10, 1, 2'd1, 0, 0, 0, 1, 16'h0009, 16'h0009, 16'h0009); step();
    id(1, 4'hF, 2'd1, 2'd2, 2'd3, 16'h0006, 16'h0007, 16'h0);
    push("nop_opc", 1, 2'b00, 0, 2'd3, 0, 0, 0, 0, 16'h0006, 16'h0007, 16'h0007); step();
    id(0, 4'd0, 2'd1, 2'd2, 2'd3, 16'h0006, 16'h0007, 16'h0);
    bubble("id_invalid"); step();

    // Asynchronous reset mid-cycle discards a held SUB
    id(1, 4'd1, 2'd2, 2'd3, 2'd1, 16'd9, 16'd4, 16'h0);
    push("sub", 1, 2'b10, 1, 2'd1, 1, 0, 0, 0, 16'd9, 16'd4, 16'd4); step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", ex_valid, 1'b0);
    chk("arst.op", ex_op, 2'b00);
    chk("arst.binv", ex_binvert, 1'b0);
    chk("arst.cin", ex_carryin, 1'b0);
    chk("arst.a", ex_a, 16'h0);
    @(negedge clk); rst_n = 1'b1;

    chk("sb_drained", 16'(sb_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
